unary_encoder: RTL and testbench
================================

UNARY_ENCODER -- requirements
Module: unary_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the magnitude bitwidth; window length is 2^WIDTH-1 cycles.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, signalling that a magnitude/sign pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1, signalling that the offered pair is accepted this cycle.
REQ-006 The block SHALL have port in_mag, input, WIDTH, the unsigned magnitude to encode.
REQ-007 The block SHALL have port in_neg, input, 1, marking a negative value.
REQ-008 The block SHALL have port flush, input, 1, a synchronous abort of the current window.
REQ-009 The block SHALL have port stream, output, 1, the unary bit feeding a MAC cell a/b input.
REQ-010 The block SHALL have port pos, output, 1, the sign feeding a MAC cell pos input (1 = positive).
REQ-011 The block SHALL have port first, output, 1, high on the first cycle of a window.
REQ-012 The block SHALL have port last, output, 1, high on the final cycle of a window.
REQ-013 The block SHALL have port busy, output, 1, high while a window is in progress.

Function
REQ-014 The block SHALL implement two states, IDLE and STREAM, with a window counter cnt of WIDTH bits.
REQ-015 A pair SHALL be accepted on a rising edge with in_valid & in_ready; in_mag and in_neg are then captured into mag_q and neg_q.
REQ-016 in_ready SHALL be 1 in IDLE and on the last cycle of STREAM (back-to-back windows with no gap), and 0 otherwise.
REQ-017 On acceptance the block SHALL enter STREAM with cnt=0, so the first stream bit appears in the cycle after the accepting edge (latency 1).
REQ-018 In STREAM, cnt SHALL increment each cycle; last = (cnt == 2^WIDTH-2); first = (cnt == 0).
REQ-019 On the last cycle: with acceptance, the block SHALL restart at cnt=0 with the new pair; without acceptance, it SHALL return to IDLE.
REQ-020 stream SHALL be busy & (key < mag_q), where key is defined by REQ-032/033.
REQ-021 pos SHALL be ~neg_q while busy and 1 in IDLE.
REQ-022 Over one window, the count of stream=1 cycles SHALL equal mag_q exactly for all mag_q in 0..2^WIDTH-1; mag_q=0 gives all zeros and mag_q=2^WIDTH-1 gives all ones.
REQ-023 flush SHALL force IDLE on the next edge, override a simultaneous acceptance (in_ready=0 while flush=1), and take effect even on the last cycle.
REQ-024 All outputs SHALL decode from registered state only, with no combinational path from in_* or flush except in_ready depending on flush.
REQ-025 In IDLE, stream, first and last SHALL be 0.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, with cnt=0, mag_q=0 and neg_q=0.
REQ-027 Under reset, outputs SHALL be stream=0, pos=1, first=0, last=0, busy=0 and in_ready=1.
REQ-028 Reset mid-window SHALL discard the window, with no further stream bits.
REQ-029 Deassertion SHALL be used as-is; the block has no internal synchronizer.

Configuration
REQ-030 Macro UNARY_DITHER_EN SHALL select the coding scheme.
REQ-031 No other behaviour SHALL differ between the two modes.
REQ-032 Without UNARY_DITHER_EN, key SHALL equal cnt (thermometer coding: ones first, then zeros).
REQ-033 With UNARY_DITHER_EN, key SHALL equal bit_reverse(cnt) over WIDTH bits (ones spread evenly across the window).

Structure
REQ-034 Package unary_pkg SHALL hold the state enum (IDLE, STREAM) and a WIDTH-parameterised last-count constant/function (2^WIDTH-2).
REQ-035 Sub-module bit_reverse SHALL be a parameterised WIDTH combinational reversal, instantiated only under UNARY_DITHER_EN.

Verification
REQ-036 WIDTH=4, no macro, accept mag=3 neg=0 -> 15-cycle window, stream 1,1,1 then twelve 0s, pos=1, first on cycle 1, last on cycle 15, busy then drops.
REQ-037 WIDTH=4, UNARY_DITHER_EN, mag=3 neg=1 -> stream=1 only at cnt 0, 4, 8, pos=0 throughout, three ones total.
REQ-038 WIDTH=4, in_valid held high with mag 15 then 0 -> in_ready pulses on last cycles, 15 ones followed immediately by 15 zeros, no IDLE gap.
REQ-039 WIDTH=4, sweep mag 0..15 in both modes -> ones per window equal mag exactly.
REQ-040 WIDTH=4, flush at cnt=5 with in_valid=1 -> in_ready=0, IDLE next cycle, no acceptance; also reset asserted at cnt=7 -> outputs at reset values immediately.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and constants for the unary (stochastic-style) magnitude encoder.
package unary_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Counter value on the final cycle of a 2^w-1 cycle window.
  function automatic int last_cnt(input int w);
    return (1 << w) - 2;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal of a WIDTH-bit word.
// Only needed by dithered builds (UNARY_DITHER_EN), so it is compiled only there.
`ifdef UNARY_DITHER_EN
module bit_reverse #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dout[i] = din[WIDTH-1-i];
    end
  end

endmodule
`endif

// File: rtl/unary_encoder.sv
// Turns a sign/magnitude pair into a 2^WIDTH-1 cycle unary bit window; first bit one cycle after accept.
// Ready only when idle or on the last window cycle (no gap back-to-back); UNARY_DITHER_EN spreads the ones.
module unary_encoder
  import unary_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_neg,
  input  logic             flush,
  output logic             stream,
  output logic             pos,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(last_cnt(WIDTH));

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] mag_q;
  logic             neg_q;
  logic [WIDTH-1:0] key;
  logic             accept;

  // The window never reaches the all-ones count, so exactly mag_q keys fall below mag_q
  // whether key is the count itself or its bit reversal.
`ifdef UNARY_DITHER_EN
  bit_reverse #(
    .WIDTH (WIDTH)
  ) u_bit_reverse (
    .din  (cnt_q),
    .dout (key)
  );
`else
  assign key = cnt_q;
`endif

  assign busy     = (state_q == STREAM);
  assign first    = busy & (cnt_q == '0);
  assign last     = busy & (cnt_q == LAST_CNT);
  assign stream   = busy & (key < mag_q);
  assign pos      = ~(busy & neg_q);
  assign in_ready = ~flush & (~busy | last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = STREAM;
      cnt_d   = '0;
    end else if (state_q == STREAM) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mag_q <= in_mag;
        neg_q <= in_neg;
      end
    end
  end

endmodule

// File: tb/tb_unary_encoder.sv
// Self-checking bench for unary_encoder at WIDTH=4: vector table, corner sequences, random traffic.
module tb_unary_encoder;

  localparam int W   = 4;
  localparam int WIN = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_mag;
  logic         in_neg;
  logic         flush;
  logic         stream;
  logic         pos;
  logic         first;
  logic         last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model: window in progress, position inside it, captured pair.
  bit m_busy = 1'b0;
  int m_t    = 0;
  int m_mag  = 0;
  bit m_neg  = 1'b0;

  int ones_seen  = 0;
  int ready_seen = 0;
  int busy_seen  = 0;

  typedef struct {
    logic [W-1:0] mag;
    bit           neg;
    int           exp_ones;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  unary_encoder #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mag   (in_mag),
    .in_neg   (in_neg),
    .flush    (flush),
    .stream   (stream),
    .pos      (pos),
    .first    (first),
    .last     (last),
    .busy     (busy)
  );

  // Which slot of the window gets compared against the magnitude at position t.
  function automatic int key_of(input int t);
    int r;
    r = 0;
`ifdef UNARY_DITHER_EN
    for (int i = 0; i < W; i++) r = r * 2 + ((t >> i) & 1);
`else
    r = t;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("stream", 32'(stream), 32'(m_busy && (key_of(m_t) < m_mag)));
    chk("pos", 32'(pos), 32'(m_busy ? !m_neg : 1'b1));
    chk("first", 32'(first), 32'(m_busy && m_t == 0));
    chk("last", 32'(last), 32'(m_busy && m_t == WIN - 1));
    chk("in_ready", 32'(in_ready), 32'(!flush && (!m_busy || m_t == WIN - 1)));
  endtask

  // Called at a falling edge with inputs already driven for this cycle.
  task automatic cycle();
    bit acc;
    #1;
    check_all();
    if (stream === 1'b1) ones_seen++;
    if (in_ready === 1'b1) ready_seen++;
    if (busy === 1'b1) busy_seen++;
    acc = in_valid && !flush && (!m_busy || m_t == WIN - 1);
    @(posedge clk);
    if (flush) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (acc) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_mag  = int'(in_mag);
      m_neg  = in_neg;
    end else if (m_busy) begin
      if (m_t == WIN - 1) begin
        m_busy = 1'b0;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
    @(negedge clk);
  endtask

  task automatic accept_pair(input logic [W-1:0] mag, input bit neg);
    in_valid = 1'b1;
    in_mag   = mag;
    in_neg   = neg;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic push_vec(input int mag, input bit neg, input int exp_ones);
    vec_t v;
    v.mag      = W'(mag);
    v.neg      = neg;
    v.exp_ones = exp_ones;
    vecs.push_back(v);
  endtask

  logic [WIN-1:0] pat;

  initial begin
    push_vec(0, 1'b0, 0);
    push_vec(15, 1'b1, 15);
    push_vec(3, 1'b0, 3);
    push_vec(3, 1'b1, 3);
    push_vec(8, 1'b0, 8);
    push_vec(1, 1'b1, 1);
    push_vec(14, 1'b0, 14);
    for (int m = 0; m < 16; m++) push_vec(m, m[0], m);

    reset    = 1'b1;
    in_valid = 1'b0;
    in_mag   = '0;
    in_neg   = 1'b0;
    flush    = 1'b0;
    #2;
    chk("rst_stream", 32'(stream), 32'd0);
    chk("rst_pos", 32'(pos), 32'd1);
    chk("rst_first", 32'(first), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Table: one full window per record, ones counted per window.
    foreach (vecs[i]) begin
      accept_pair(vecs[i].mag, vecs[i].neg);
      ones_seen = 0;
      repeat (WIN) cycle();
      chk($sformatf("ones_mag%0d", vecs[i].mag), 32'(ones_seen), 32'(vecs[i].exp_ones));
      chk("idle_after_window", 32'(busy), 32'd0);
    end

    // Exact bit pattern of a magnitude-3 window.
`ifdef UNARY_DITHER_EN
    pat = 15'b000_0001_0001_0001;
    accept_pair(4'd3, 1'b1);
`else
    pat = 15'b000_0000_0000_0111;
    accept_pair(4'd3, 1'b0);
`endif
    for (int t = 0; t < WIN; t++) begin
      chk($sformatf("pattern_t%0d", t), 32'(stream), 32'(pat[t]));
      cycle();
    end
    chk("pattern_busy_drop", 32'(busy), 32'd0);

    // Back-to-back windows with in_valid held: 15 ones then 15 zeros, no gap.
    in_valid   = 1'b1;
    in_mag     = 4'd15;
    in_neg     = 1'b0;
    cycle();
    in_mag     = 4'd0;
    ones_seen  = 0;
    ready_seen = 0;
    busy_seen  = 0;
    repeat (WIN) cycle();
    in_valid = 1'b0;
    chk("b2b_ones_w1", 32'(ones_seen), 32'd15);
    chk("b2b_ready_pulses", 32'(ready_seen), 32'd1);
    ones_seen = 0;
    repeat (WIN) cycle();
    chk("b2b_ones_w2", 32'(ones_seen), 32'd0);
    chk("b2b_busy_cycles", 32'(busy_seen), 32'(2 * WIN));
    cycle();

    // Flush at cnt=5 with a competing offer.
    accept_pair(4'd15, 1'b0);
    repeat (5) cycle();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_mag   = 4'd9;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle", 32'(busy), 32'd0);
    cycle();
    chk("flush_no_accept", 32'(busy), 32'd0);

    // Asynchronous reset at cnt=7 mid-window.
    accept_pair(4'd15, 1'b1);
    repeat (7) cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_stream", 32'(stream), 32'd0);
    chk("midrst_pos", 32'(pos), 32'd1);
    chk("midrst_first", 32'(first), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    m_busy = 1'b0;
    m_t    = 0;
    @(negedge clk);
    chk("midrst_held", 32'(busy), 32'd0);
    reset = 1'b0;
    cycle();
    chk("midrst_no_resume", 32'(stream), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_mag   = W'($urandom_range(0, 15));
      in_neg   = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 39) == 0);
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (WIN + 1) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
